// File: rtl/view_pkg.sv
// Shared defaults and FSM state encoding for the layered draw sequencer.
package view_pkg;

   localparam int          DEF_NUM_LAYERS = 4;
   localparam int          DEF_X_W        = 9;
   localparam int          DEF_Y_W        = 8;
   localparam int          DEF_COLOR_W    = 12;
   localparam logic [11:0] DEF_KEY_COLOR  = 12'h000;
   localparam int          DEF_TIMEOUT    = 131071;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_SELECT = 3'd1;
   localparam state_t S_RUN    = 3'd2;
   localparam state_t S_NEXT   = 3'd3;
   localparam state_t S_FINISH = 3'd4;

endpackage

// File: rtl/draw_sequencer_if.sv
// Layer-drawer / VGA-adapter bundle of the draw sequencer. The sequencer
// uses the slave view; whatever feeds layers and consumes pixels uses master.
interface draw_sequencer_if #(
   parameter int NUM_LAYERS = view_pkg::DEF_NUM_LAYERS,
   parameter int X_W        = view_pkg::DEF_X_W,
   parameter int Y_W        = view_pkg::DEF_Y_W,
   parameter int COLOR_W    = view_pkg::DEF_COLOR_W
);

   logic                          frame_start;
   logic [NUM_LAYERS-1:0]         layer_mask;
   logic [NUM_LAYERS-1:0]         key_en;
   logic [NUM_LAYERS*X_W-1:0]     layer_x;
   logic [NUM_LAYERS*Y_W-1:0]     layer_y;
   logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
   logic [NUM_LAYERS-1:0]         layer_we;
   logic [NUM_LAYERS-1:0]         layer_done;
   logic [NUM_LAYERS-1:0]         layer_enable;
   logic [X_W-1:0]                X_out;
   logic [Y_W-1:0]                Y_out;
   logic [COLOR_W-1:0]            Color_out;
   logic                          writeEn;
   logic                          busy;
   logic                          frame_done;
   logic                          overrun;
   logic                          timeout_err;

   modport master (
      output frame_start, layer_mask, key_en, layer_x, layer_y, layer_color,
             layer_we, layer_done,
      input  layer_enable, X_out, Y_out, Color_out, writeEn, busy, frame_done,
             overrun, timeout_err
   );

   modport slave (
      input  frame_start, layer_mask, key_en, layer_x, layer_y, layer_color,
             layer_we, layer_done,
      output layer_enable, X_out, Y_out, Color_out, writeEn, busy, frame_done,
             overrun, timeout_err
   );

endinterface

// File: rtl/layer_pixel_mux.sv
// Selects the active layer's pixel slice and flags colour-keyed pixels.
// An out-of-range index yields an all-zero, non-writing pixel.
module layer_pixel_mux
   import view_pkg::*;
#(
   parameter int                 NUM_LAYERS = DEF_NUM_LAYERS,
   parameter int                 X_W        = DEF_X_W,
   parameter int                 Y_W        = DEF_Y_W,
   parameter int                 COLOR_W    = DEF_COLOR_W,
   parameter logic [COLOR_W-1:0] KEY_COLOR  = DEF_KEY_COLOR,
   parameter int                 IDX_W      = $clog2(NUM_LAYERS + 1)
) (
   input  logic [IDX_W-1:0]              i_idx,
   input  logic [NUM_LAYERS*X_W-1:0]     i_layer_x,
   input  logic [NUM_LAYERS*Y_W-1:0]     i_layer_y,
   input  logic [NUM_LAYERS*COLOR_W-1:0] i_layer_color,
   input  logic [NUM_LAYERS-1:0]         i_layer_we,
   input  logic [NUM_LAYERS-1:0]         i_layer_done,
   input  logic [NUM_LAYERS-1:0]         i_key_en,
   output logic [X_W-1:0]                o_x,
   output logic [Y_W-1:0]                o_y,
   output logic [COLOR_W-1:0]            o_color,
   output logic                          o_we,
   output logic                          o_done,
   output logic                          o_keyed
);

   localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic [X_W-1:0]     w_x_arr [NUM_LAYERS];
   logic [Y_W-1:0]     w_y_arr [NUM_LAYERS];
   logic [COLOR_W-1:0] w_c_arr [NUM_LAYERS];
   logic [SEL_W-1:0]   w_sel;
   logic               w_valid;

   for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_slice
      assign w_x_arr[gi] = i_layer_x[gi*X_W +: X_W];
      assign w_y_arr[gi] = i_layer_y[gi*Y_W +: Y_W];
      assign w_c_arr[gi] = i_layer_color[gi*COLOR_W +: COLOR_W];
   end

   assign w_sel   = i_idx[SEL_W-1:0];
   assign w_valid = (i_idx < IDX_W'(NUM_LAYERS));

   always_comb begin
      o_x     = '0;
      o_y     = '0;
      o_color = '0;
      o_we    = 1'b0;
      o_done  = 1'b0;
      o_keyed = 1'b0;
      if (w_valid) begin
         o_x     = w_x_arr[w_sel];
         o_y     = w_y_arr[w_sel];
         o_color = w_c_arr[w_sel];
         o_we    = i_layer_we[w_sel];
         o_done  = i_layer_done[w_sel];
         // Key on the incoming colour so the decision is never a cycle stale.
         o_keyed = i_key_en[w_sel] && (w_c_arr[w_sel] == KEY_COLOR);
      end
   end

endmodule

// File: rtl/draw_sequencer.sv
// Steps through the masked drawing layers bottom-up, enabling one drawer at a
// time and forwarding its pixels to the VGA adapter with one cycle of latency.
module draw_sequencer
   import view_pkg::*;
#(
   parameter int                 NUM_LAYERS = DEF_NUM_LAYERS,
   parameter int                 X_W        = DEF_X_W,
   parameter int                 Y_W        = DEF_Y_W,
   parameter int                 COLOR_W    = DEF_COLOR_W,
   parameter logic [COLOR_W-1:0] KEY_COLOR  = DEF_KEY_COLOR,
   parameter int                 TIMEOUT    = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             resetn,
   draw_sequencer_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_LAYERS + 1);
   localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [NUM_LAYERS-1:0] r_mask;
   logic [NUM_LAYERS-1:0] r_key;
   logic [X_W-1:0]        r_x;
   logic [Y_W-1:0]        r_y;
   logic [COLOR_W-1:0]    r_color;
   logic                  r_we;
   logic                  r_overrun;
   logic                  r_timeout_err;

   logic [X_W-1:0]        w_x;
   logic [Y_W-1:0]        w_y;
   logic [COLOR_W-1:0]    w_color;
   logic                  w_we;
   logic                  w_done;
   logic                  w_keyed;
   logic                  w_run;
   logic                  w_last;
   logic                  w_mask_bit;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_timeout;

   layer_pixel_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .X_W        (X_W),
      .Y_W        (Y_W),
      .COLOR_W    (COLOR_W),
      .KEY_COLOR  (KEY_COLOR),
      .IDX_W      (IDX_W)
   ) u_mux (
      .i_idx         (r_idx),
      .i_layer_x     (bus.layer_x),
      .i_layer_y     (bus.layer_y),
      .i_layer_color (bus.layer_color),
      .i_layer_we    (bus.layer_we),
      .i_layer_done  (bus.layer_done),
      .i_key_en      (r_key),
      .o_x           (w_x),
      .o_y           (w_y),
      .o_color       (w_color),
      .o_we          (w_we),
      .o_done        (w_done),
      .o_keyed       (w_keyed)
   );

   assign w_run      = (r_state == S_RUN);
   assign w_last     = (r_idx == IDX_W'(NUM_LAYERS));
   assign w_mask_bit = r_mask[r_idx[SEL_W-1:0]];
   // Saturating count; the layer is cut off in the cycle the count would reach TIMEOUT.
   assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_mask        <= '0;
         r_key         <= '0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (bus.frame_start && (r_state != S_IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.frame_start) begin
                  r_mask  <= bus.layer_mask;
                  r_key   <= bus.key_en;
                  r_idx   <= '0;
                  r_state <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (w_last)
                  r_state <= S_FINISH;
               else if (!w_mask_bit)
                  r_idx <= r_idx + IDX_W'(1);
               else
                  r_state <= S_RUN;
            end
            S_RUN: begin
               r_cnt <= w_cnt_next;
               if (w_done || w_timeout) begin
                  r_state <= S_NEXT;
                  if (!w_done)
                     r_timeout_err <= 1'b1;
               end
            end
            S_NEXT: begin
               r_cnt   <= '0;
               r_idx   <= r_idx + IDX_W'(1);
               r_state <= S_SELECT;
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_x     <= '0;
         r_y     <= '0;
         r_color <= '0;
         r_we    <= 1'b0;
      end else begin
         if (w_run) begin
            r_x     <= w_x;
            r_y     <= w_y;
            r_color <= w_color;
         end
         r_we <= w_run && w_we && !w_keyed;
      end
   end

   assign bus.layer_enable = w_run ? (NUM_LAYERS'(1) << r_idx[SEL_W-1:0]) : '0;
   assign bus.X_out        = r_x;
   assign bus.Y_out        = r_y;
   assign bus.Color_out    = r_color;
   assign bus.writeEn      = r_we;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.frame_done   = (r_state == S_FINISH);
   assign bus.overrun      = r_overrun;
   assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboarded bench for draw_sequencer: stimulus queues expected pixels, a
// monitor pops and compares them whenever writeEn is seen.
`timescale 1ns/1ps
module tb_draw_sequencer;
   import view_pkg::*;

   localparam int NL = 4;
   localparam int XW = 9;
   localparam int YW = 8;
   localparam int CW = 12;

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
      int            due;
   } px_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   draw_sequencer_if #(.NUM_LAYERS(NL), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bus ();

   draw_sequencer #(
      .NUM_LAYERS (NL),
      .X_W        (XW),
      .Y_W        (YW),
      .COLOR_W    (CW),
      .KEY_COLOR  (12'h000),
      .TIMEOUT    (20)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   px_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  tick     = 0;
   int  wr_count = 0;
   int  fd_count = 0;
   int  en_cnt[NL];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Monitor: samples 1 ns after each rising edge.
   initial begin
      for (int i = 0; i < NL; i++) en_cnt[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         tick++;
         for (int i = 0; i < NL; i++)
            if (bus.layer_enable[i]) en_cnt[i]++;
         if (bus.frame_done) begin
            fd_count++;
            $display("t=%0d frame_done #%0d", tick, fd_count);
         end
         if (bus.writeEn) begin
            px_t e;
            wr_count++;
            $display("t=%0d write x=%0h y=%0h c=%0h", tick, bus.X_out, bus.Y_out, bus.Color_out);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("px_x", bus.X_out, e.x);
               chk("px_y", bus.Y_out, e.y);
               chk("px_color", bus.Color_out, e.c);
               chk("px_latency", tick, e.due);
            end
         end
      end
   end

   task automatic quiet();
      bus.frame_start = 1'b0;
      bus.layer_we    = '0;
      bus.layer_done  = '0;
      bus.layer_x     = '0;
      bus.layer_y     = '0;
      bus.layer_color = '0;
   endtask

   task automatic release_in();
      @(negedge clk);
      quiet();
   endtask

   task automatic start_frame(input logic [NL-1:0] m, input logic [NL-1:0] k);
      @(negedge clk);
      quiet();
      bus.layer_mask  = m;
      bus.key_en      = k;
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   // One cycle of layer l activity plus we/done noise on a neighbouring layer.
   task automatic drive_px(input int l, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c, input bit we, input bit done, input bit expw);
      int  o;
      px_t e;
      @(negedge clk);
      quiet();
      o = (l + 1) % NL;
      bus.layer_x[o*XW +: XW]     = 9'h1FF;
      bus.layer_y[o*YW +: YW]     = 8'hEE;
      bus.layer_color[o*CW +: CW] = 12'h0A5;
      bus.layer_we[o]             = 1'b1;
      bus.layer_done[o]           = 1'b1;
      bus.layer_x[l*XW +: XW]     = x;
      bus.layer_y[l*YW +: YW]     = y;
      bus.layer_color[l*CW +: CW] = c;
      bus.layer_we[l]             = we;
      bus.layer_done[l]           = done;
      if (expw) begin
         e.x = x; e.y = y; e.c = c; e.due = tick + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_en(input logic [NL-1:0] exp, input string nm);
      int n;
      n = 0;
      while (bus.layer_enable == '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, bus.layer_enable, exp);
   endtask

   task automatic wait_fd(input int exp_total, input string nm);
      int n;
      n = 0;
      while (fd_count < exp_total && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, fd_count, exp_total);
   endtask

   initial begin
      int n;
      int s[NL];
      quiet();
      bus.layer_mask = '0;
      bus.key_en     = '0;

      #12;
      chk("rst_enable", bus.layer_enable, 0);
      chk("rst_writeEn", bus.writeEn, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_X_out", bus.X_out, 0);
      chk("rst_Color_out", bus.Color_out, 0);
      @(negedge clk);
      resetn = 1'b1;

      // Frame 1: all layers, three F00 pixels each, in layer order.
      start_frame(4'hF, 4'h0);
      for (int l = 0; l < NL; l++) begin
         wait_en(4'(1 << l), "f1_enable");
         for (int p = 0; p < 3; p++)
            drive_px(l, 9'(l*10 + p + 1), 8'(l + 2*p + 1), 12'hF00, 1'b1, (l < 2 && p == 2), 1'b1);
         if (l >= 2) drive_px(l, 9'h0, 8'h0, 12'h0, 1'b0, 1'b1, 1'b0);
         release_in();
      end
      wait_fd(1, "f1_frame_done");
      chk("f1_write_count", wr_count, 12);
      repeat (3) @(negedge clk);
      chk("f1_idle_busy", bus.busy, 0);
      chk("f1_single_pulse", fd_count, 1);

      // Frame 2: mask 0101 skips layers 1 and 3.
      for (int i = 0; i < NL; i++) s[i] = en_cnt[i];
      start_frame(4'b0101, 4'h0);
      wait_en(4'b0001, "f2_enable_l0");
      drive_px(0, 9'd5, 8'd6, 12'h123, 1'b1, 1'b1, 1'b1);
      release_in();
      wait_en(4'b0100, "f2_enable_l2");
      drive_px(2, 9'd7, 8'd8, 12'h456, 1'b1, 1'b0, 1'b1);
      drive_px(2, 9'd0, 8'd0, 12'h0, 1'b0, 1'b1, 1'b0);
      release_in();
      wait_fd(2, "f2_frame_done");
      chk("f2_l1_never_enabled", en_cnt[1] - s[1], 0);
      chk("f2_l3_never_enabled", en_cnt[3] - s[3], 0);
      chk("f2_write_count", wr_count, 14);

      // Frame 3: keying on layer 1 only.
      start_frame(4'b0011, 4'b0010);
      wait_en(4'b0001, "f3_enable_l0");
      drive_px(0, 9'd11, 8'd12, 12'h000, 1'b1, 1'b1, 1'b1);
      release_in();
      wait_en(4'b0010, "f3_enable_l1");
      drive_px(1, 9'd13, 8'd14, 12'h000, 1'b1, 1'b0, 1'b0);
      drive_px(1, 9'd15, 8'd16, 12'h0F0, 1'b1, 1'b1, 1'b1);
      release_in();
      wait_fd(3, "f3_frame_done");
      chk("f3_write_count", wr_count, 16);

      // Frame 4: layer 2 never finishes and is cut off after 20 cycles.
      chk("f4_timeout_err_before", bus.timeout_err, 0);
      start_frame(4'b1100, 4'h0);
      wait_en(4'b0100, "f4_enable_l2");
      n = 0;
      while (bus.layer_enable == 4'b0100 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("f4_timeout_cycles", n, 20);
      chk("f4_timeout_err", bus.timeout_err, 1);
      wait_en(4'b1000, "f4_enable_l3");
      drive_px(3, 9'd21, 8'd22, 12'hABC, 1'b1, 1'b1, 1'b1);
      release_in();
      wait_fd(4, "f4_frame_done");

      // Frame 5: frame_start mid-frame is ignored but flagged.
      chk("f5_overrun_before", bus.overrun, 0);
      start_frame(4'b0001, 4'h0);
      wait_en(4'b0001, "f5_enable_l0");
      start_frame(4'hF, 4'h0);
      chk("f5_overrun", bus.overrun, 1);
      drive_px(0, 9'd31, 8'd32, 12'h321, 1'b1, 1'b1, 1'b1);
      release_in();
      wait_fd(5, "f5_frame_done");
      repeat (20) @(negedge clk);
      chk("f5_single_frame", fd_count, 5);
      chk("f5_idle_busy", bus.busy, 0);
      chk("f5_overrun_sticky", bus.overrun, 1);

      // Frame 6: reset asserted while a layer is running.
      start_frame(4'b0001, 4'h0);
      wait_en(4'b0001, "f6_enable_l0");
      drive_px(0, 9'h1AB, 8'hCD, 12'hFED, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("f6_rst_enable", bus.layer_enable, 0);
      chk("f6_rst_writeEn", bus.writeEn, 0);
      chk("f6_rst_X_out", bus.X_out, 0);
      chk("f6_rst_Y_out", bus.Y_out, 0);
      chk("f6_rst_Color_out", bus.Color_out, 0);
      chk("f6_rst_busy", bus.busy, 0);
      chk("f6_rst_overrun", bus.overrun, 0);
      chk("f6_rst_timeout_err", bus.timeout_err, 0);
      repeat (3) @(negedge clk);
      quiet();
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("f6_idle_after_reset", bus.busy, 0);

      // Frame 7: empty mask walks NUM_LAYERS+1 SELECT cycles then FINISH.
      start_frame(4'b0000, 4'h0);
      n = 0;
      while (bus.busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("f7_busy_cycles", n, 6);
      wait_fd(6, "f7_frame_done");
      chk("f7_write_count", wr_count, 19);
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; the ports SHALL be named clk and resetn.
REQ-002 Parameters SHALL be, one per line:
- NUM_LAYERS, 4, number of drawing layers; layer 0 is drawn first (bottom).
- X_W, 9, X coordinate width.
- Y_W, 8, Y coordinate width.
- COLOR_W, 12, pixel colour width.
- KEY_COLOR, 12'h000, transparent colour value.
- TIMEOUT, 131071, maximum cycles a layer may stay active.
REQ-003 Ports SHALL be, one per line:
- clk, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- frame_start, in, 1, one-cycle pulse that starts a frame.
- layer_mask, in, NUM_LAYERS, bit i=1 means layer i is drawn this frame.
- key_en, in, NUM_LAYERS, bit i=1 means colour keying applies to layer i.
- layer_x, in, NUM_LAYERS*X_W, packed pixel X coordinates; layer i occupies slice i.
- layer_y, in, NUM_LAYERS*Y_W, packed pixel Y coordinates.
- layer_color, in, NUM_LAYERS*COLOR_W, packed pixel colours.
- layer_we, in, NUM_LAYERS, per-layer pixel-valid strobes.
- layer_done, in, NUM_LAYERS, per-layer completion pulses.
- layer_enable, out, NUM_LAYERS, one-hot start/enable to layer drawers.
- X_out, out, X_W, registered pixel X to the VGA adapter.
- Y_out, out, Y_W, registered pixel Y.
- Color_out, out, COLOR_W, registered pixel colour.
- writeEn, out, 1, registered pixel write strobe.
- busy, out, 1, high while a frame is being drawn.
- frame_done, out, 1, one-cycle pulse at frame end.
- overrun, out, 1, sticky flag: frame_start arrived while busy.
- timeout_err, out, 1, sticky flag: a layer exceeded TIMEOUT.

Function
REQ-004 The FSM SHALL have the states IDLE, SELECT, RUN, NEXT and FINISH.
REQ-005 In IDLE, a frame_start pulse SHALL latch layer_mask and key_en, set idx=0, and move to SELECT.
REQ-006 In SELECT, if idx=NUM_LAYERS the FSM SHALL go to FINISH; else if the latched mask bit idx=0 it SHALL increment idx and stay in SELECT (one cycle per skipped layer); else it SHALL go to RUN.
REQ-007 In RUN, layer_enable SHALL be one-hot at bit idx, and all other bits SHALL be 0.
REQ-008 RUN SHALL exit to NEXT on layer_done[idx], or when the per-layer cycle counter reaches TIMEOUT; a timeout SHALL also set timeout_err.
REQ-009 In NEXT, the FSM SHALL drop layer_enable, clear the cycle counter, increment idx, and go to SELECT.
REQ-010 In FINISH, the FSM SHALL pulse frame_done for one cycle and return to IDLE.
REQ-011 busy SHALL be high in every state except IDLE.
REQ-012 The pixel path SHALL have a latency of exactly one cycle: X_out, Y_out and Color_out SHALL register the idx slice while in RUN and SHALL hold their value otherwise.
REQ-013 writeEn SHALL equal the registered value of (state==RUN AND layer_we[idx] AND NOT(latched key_en[idx] AND layer_color[idx]==KEY_COLOR)).
REQ-014 Keying SHALL compare the incoming colour, not the registered Color_out.
REQ-015 In the cycle layer_done[idx] is asserted, a simultaneous layer_we[idx] pixel SHALL still be written.
REQ-016 layer_done and layer_we of non-selected layers SHALL be ignored.
REQ-017 A frame_start while busy SHALL be ignored and SHALL set overrun; the sticky flags SHALL clear only on reset.
REQ-018 A frame with all mask bits 0 SHALL reach FINISH after NUM_LAYERS+1 SELECT cycles and SHALL produce no writeEn.
REQ-019 The cycle counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate rather than wrap.

Reset
REQ-020 resetn low SHALL asynchronously force state=IDLE, idx=0, counter=0, layer_enable=0, X_out=0, Y_out=0, Color_out=0, writeEn=0, busy=0, frame_done=0, overrun=0, timeout_err=0.
REQ-021 A reset during RUN SHALL drop layer_enable in the same cycle, with no further writeEn.

Structure
REQ-022 The state encoding and the default widths/KEY_COLOR SHALL live in the shared package view_pkg.
REQ-023 The per-layer slice mux plus key compare SHALL be one sub-module, layer_pixel_mux (combinational, parameterised the same way).

Verification
REQ-024 Mask=4'b1111, each layer emits 3 pixels (colour 12'hF00) then done -> 12 writeEn cycles, in layer order 0..3, one cycle after each input, then one frame_done.
REQ-025 Mask=4'b0101 -> layer_enable shows only 4'b0001 then 4'b0100; layers 1 and 3 stay at 0 throughout.
REQ-026 key_en=4'b0010, layer 1 emits colours 12'h000, 12'h0F0 -> only the 12'h0F0 pixel is written; 12'h000 on layer 0 (key off) is written.
REQ-027 TIMEOUT=20, layer 2 never asserts done -> exit after 20 cycles, timeout_err=1, layer 3 still drawn, frame_done pulses.
REQ-028 frame_start pulsed mid-frame -> overrun=1 and the frame completes once; resetn pulsed in RUN -> all outputs 0 immediately, FSM in IDLE.
